// File: rtl/riscv_mem_pkg.sv
// Shared constants for the data-side memory subsystem: MMIO register offsets,
// STAT field positions and the address-decode region type.
package riscv_mem_pkg;

  localparam logic [11:0] OFF_GPIO  = 12'h000;
  localparam logic [11:0] OFF_CYCLE = 12'h004;
  localparam logic [11:0] OFF_TXD   = 12'h008;
  localparam logic [11:0] OFF_STAT  = 12'h00C;
  localparam logic [11:0] OFF_DROP  = 12'h010;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_COUNT_LSB = 2;
  localparam int unsigned STAT_COUNT_W   = 6;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and a combinational head output.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // Fullness is judged before this cycle's pop, so a push into a full FIFO drops.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: byte-enabled word RAM plus an MMIO window
// holding GPIO, a free-running cycle counter, a TX byte FIFO and a dropped-push counter.
module dmem_mmio
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       a,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RamBytes = 32'(DEPTH_WORDS) * 32'd4;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [31:0]       ram_word_d;
  logic [IdxW-1:0]   ram_idx;
  region_e           region;
  logic [11:0]       mmio_off;
  logic              mmio_wr;

  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [15:0]       drop_q, drop_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [6:0]        count_ext;
  logic [31:0]       stat_word;
  logic              unused_count_msb;

  // Address decode; RAM wins if the MMIO window were ever placed inside it.
  always_comb begin
    region = REG_NONE;
    if (a < RamBytes) begin
      region = REG_RAM;
    end else if (a[31:12] == MMIO_BASE[31:12]) begin
      region = REG_MMIO;
    end
  end

  assign ram_idx  = a[IdxW+1:2];
  assign mmio_off = {a[11:2], 2'b00};

  // RAM: merge enabled bytes into the current word; not reset and written even during reset.
  always_comb begin
    ram_word_d = mem_q[ram_idx];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) ram_word_d[8*i +: 8] = wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we && (region == REG_RAM)) mem_q[ram_idx] <= ram_word_d;
  end

  // MMIO stores need all four byte lanes and are discarded while reset is high.
  assign mmio_wr   = we && (be == 4'b1111) && (region == REG_MMIO) && !reset;
  assign fifo_push = mmio_wr && (mmio_off == OFF_TXD);
  assign fifo_pop  = tx_valid & tx_ready;

  always_comb begin
    gpio_d  = gpio_q;
    cycle_d = cycle_q + 32'd1;
    drop_d  = drop_q;
    if (mmio_wr) begin
      case (mmio_off)
        OFF_GPIO:  gpio_d  = wd[GPIO_W-1:0];
        OFF_CYCLE: cycle_d = wd;
        OFF_TXD: begin
          if (fifo_full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q  <= '0;
      cycle_q <= '0;
      drop_q  <= '0;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid = ~fifo_empty;
  assign gpio_out = gpio_q;

  // STAT exposes only six count bits; a 64-deep full FIFO reads count 0 with full set.
  assign count_ext        = 7'(fifo_count);
  assign unused_count_msb = count_ext[6];

  always_comb begin
    stat_word = '0;
    stat_word[STAT_COUNT_LSB +: STAT_COUNT_W] = count_ext[5:0];
    stat_word[STAT_EMPTY_BIT] = fifo_empty;
    stat_word[STAT_FULL_BIT]  = fifo_full;
  end

  always_comb begin
    rd = '0;
    case (region)
      REG_RAM: rd = mem_q[ram_idx];
      REG_MMIO: begin
        case (mmio_off)
          OFF_GPIO:  rd = 32'(gpio_q);
          OFF_CYCLE: rd = cycle_q;
          OFF_STAT:  rd = stat_word;
          OFF_DROP:  rd = {16'h0000, drop_q};
          default:   rd = '0;
        endcase
      end
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed vector table, hand-written FIFO/reset sequences and
// random traffic, all checked against a queue/array model of the memory map.
module tb_dmem_mmio;

  localparam int unsigned DW = 64;
  localparam logic [31:0] MB = 32'h0000_1000;
  localparam int unsigned FD = 8;
  localparam int unsigned GW = 8;

  logic          clk, reset, we, tx_ready, tx_valid;
  logic [3:0]    be;
  logic [31:0]   a, wd, rd;
  logic [GW-1:0] gpio_out;
  logic [7:0]    tx_data;

  dmem_mmio #(
    .DEPTH_WORDS (DW),
    .MMIO_BASE   (MB),
    .FIFO_DEPTH  (FD),
    .GPIO_W      (GW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .be       (be),
    .a        (a),
    .wd       (wd),
    .rd       (rd),
    .gpio_out (gpio_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]   mem_m [DW];
  bit            known_m [DW];
  logic [GW-1:0] gpio_m;
  logic [31:0]   cyc_m;
  logic [15:0]   drop_m;
  logic [7:0]    q_m [$];

  typedef struct {
    string       name;
    logic        r;
    logic        w;
    logic [3:0]  b;
    logic [31:0] ad;
    logic [31:0] d;
    logic        rdy;
    logic        chk_en;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] addr);
    return addr < DW * 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (is_ram(addr)) return mem_m[addr / 4];
    if (addr[31:12] == MB[31:12]) begin
      case (addr[11:0] & 12'hFFC)
        12'h000: return 32'(gpio_m);
        12'h004: return cyc_m;
        12'h00C: return {24'h0, 6'(q_m.size()), q_m.size() == 0, q_m.size() == FD};
        12'h010: return {16'h0, drop_m};
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  // Drive one cycle's inputs and check everything observable before the edge.
  task automatic apply(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] ad, input logic [31:0] d, input logic rdy);
    reset = r; we = w; be = b; a = ad; wd = d; tx_ready = rdy;
    #1;
    if (!(is_ram(ad) && !known_m[ad / 4])) chk("rd", rd, model_read(ad));
    chk("gpio_out", 32'(gpio_out), 32'(gpio_m));
    chk("tx_valid", 32'(tx_valid), 32'(q_m.size() != 0));
    if (q_m.size() != 0) chk("tx_data", 32'(tx_data), 32'(q_m[0]));
  endtask

  // Clock edge, then advance the model by the rules of the memory map.
  task automatic finish_cycle();
    bit          pop, push, full_pre;
    logic [31:0] nxt;
    @(posedge clk);
    if (we && is_ram(a)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_m[a / 4][8*i +: 8] = wd[8*i +: 8];
      end
      if (be == 4'hF) known_m[a / 4] = 1'b1;
    end
    if (reset) begin
      gpio_m = '0;
      cyc_m  = '0;
      drop_m = '0;
      q_m.delete();
    end else begin
      full_pre = (q_m.size() == FD);
      pop      = (q_m.size() != 0) && tx_ready;
      push     = 1'b0;
      nxt      = cyc_m + 32'd1;
      if (we && be == 4'hF && !is_ram(a) && a[31:12] == MB[31:12]) begin
        case (a[11:0] & 12'hFFC)
          12'h000: gpio_m = wd[GW-1:0];
          12'h004: nxt = wd;
          12'h008: begin
            if (full_pre) begin
              if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
            end else begin
              push = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (pop) void'(q_m.pop_front());
      if (push) q_m.push_back(wd[7:0]);
      cyc_m = nxt;
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] ad, input logic [31:0] d, input logic rdy);
    apply(r, w, b, ad, d, rdy);
    finish_cycle();
  endtask

  task automatic add(input string n, input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] ad, input logic [31:0] d, input logic rdy,
                     input logic chk_en, input logic [31:0] exp);
    vec_t v;
    v.name = n; v.r = r; v.w = w; v.b = b; v.ad = ad; v.d = d;
    v.rdy = rdy; v.chk_en = chk_en; v.exp = exp;
    vecs.push_back(v);
  endtask

  int          k;
  logic [31:0] ad_r;
  logic [3:0]  be_r;

  initial begin
    reset = 1'b1; we = 1'b0; be = '0; a = '0; wd = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    gpio_m = '0; cyc_m = '0; drop_m = '0; q_m.delete();
    foreach (known_m[i]) known_m[i] = 1'b0;
    @(negedge clk);

    // Reset state: CYCLE reads 0, gpio 0, FIFO empty (model-checked in apply)
    apply(1'b0, 1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b0);
    chk("reset_cycle", rd, 32'h0);
    finish_cycle();

    for (int i = 0; i < DW; i++) cycle(1'b0, 1'b1, 4'hF, 32'(i * 4), 32'hC0DE_0000 | 32'(i), 1'b0);

    add("ram_full",  0, 1, 4'hF, 32'h10, 32'hAABB_CCDD, 0, 1, 32'hC0DE_0004);
    add("ram_be",    0, 1, 4'h2, 32'h10, 32'h0000_1100, 0, 1, 32'hAABB_CCDD);
    add("ram_merge", 0, 0, 4'h0, 32'h10, 32'h0,         0, 1, 32'hAABB_11DD);
    for (int i = 0; i < 3; i++) add("rst", 1, 0, 4'h0, MB + 32'h4, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) add("cyc_count", 0, 0, 4'h0, MB + 32'h4, 32'h0, 0, 1, 32'(i));
    add("cyc_wr",    0, 1, 4'hF, MB + 32'h4, 32'hFFFF_FFFE, 0, 1, 32'd6);
    add("cyc_fffe",  0, 0, 4'h0, MB + 32'h4, 32'h0, 0, 1, 32'hFFFF_FFFE);
    add("cyc_ffff",  0, 0, 4'h0, MB + 32'h4, 32'h0, 0, 1, 32'hFFFF_FFFF);
    add("cyc_wrap",  0, 0, 4'h0, MB + 32'h4, 32'h0, 0, 1, 32'h0);
    add("gpio_part", 0, 1, 4'h1, MB,         32'hFF, 0, 1, 32'h0);
    add("gpio_kept", 0, 0, 4'h0, MB,         32'h0,  0, 1, 32'h0);
    add("gpio_full", 0, 1, 4'hF, MB,         32'hFF, 0, 1, 32'h0);
    add("gpio_rd",   0, 0, 4'h0, MB,         32'h0,  0, 1, 32'hFF);
    add("unmap_rd",  0, 0, 4'h0, 32'h2000,   32'h0,  0, 1, 32'h0);
    add("unmap_wr",  0, 1, 4'hF, 32'h2000,   32'h1234_5678, 0, 1, 32'h0);
    add("unmap_rd2", 0, 0, 4'h0, 32'h2000,   32'h0,  0, 1, 32'h0);
    add("win_gap",   0, 0, 4'h0, MB + 32'h14, 32'h0, 0, 1, 32'h0);
    for (int i = 1; i <= 10; i++) add("txd_rd0", 0, 1, 4'hF, MB + 32'h8, 32'(i), 0, 1, 32'h0);
    add("stat_full", 0, 0, 4'h0, MB + 32'hC,  32'h0,  0, 1, 32'h21);
    add("drop2",     0, 0, 4'h0, MB + 32'h10, 32'h0,  0, 1, 32'h2);
    add("push_pop_full", 0, 1, 4'hF, MB + 32'h8, 32'h55, 1, 1, 32'h0);
    add("stat_7",    0, 0, 4'h0, MB + 32'hC,  32'h0,  0, 1, 32'h1C);
    add("drop3",     0, 0, 4'h0, MB + 32'h10, 32'h0,  0, 1, 32'h3);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].w, vecs[i].b, vecs[i].ad, vecs[i].d, vecs[i].rdy);
      if (vecs[i].chk_en) chk(vecs[i].name, rd, vecs[i].exp);
      finish_cycle();
    end

    // Drain: 0x01 left with the dropped 0x55, so 0x02..0x08 remain in order
    for (int i = 2; i <= 8; i++) begin
      apply(1'b0, 1'b0, 4'h0, MB + 32'hC, 32'h0, 1'b1);
      chk("drain_valid", 32'(tx_valid), 32'h1);
      chk("drain_data", 32'(tx_data), 32'(i));
      finish_cycle();
    end
    apply(1'b0, 1'b0, 4'h0, MB + 32'hC, 32'h0, 1'b1);
    chk("drained_valid", 32'(tx_valid), 32'h0);
    chk("drained_stat", rd, 32'h2);
    finish_cycle();

    // Count 3, push with pop keeps count 3
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 4'hF, MB + 32'h8, 32'hA0 + 32'(i), 1'b0);
    cycle(1'b0, 1'b1, 4'hF, MB + 32'h8, 32'hA4, 1'b1);
    apply(1'b0, 1'b0, 4'h0, MB + 32'hC, 32'h0, 1'b0);
    chk("pushpop_stat", rd, 32'h0C);
    chk("pushpop_head", 32'(tx_data), 32'hA2);
    finish_cycle();

    // Reset mid-drain with 4 entries; RAM store in the reset cycle still lands
    cycle(1'b0, 1'b1, 4'hF, MB + 32'h8, 32'hB1, 1'b0);
    cycle(1'b1, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, 1'b1);
    apply(1'b0, 1'b0, 4'h0, MB + 32'hC, 32'h0, 1'b1);
    chk("rst_valid", 32'(tx_valid), 32'h0);
    chk("rst_stat", rd, 32'h2);
    finish_cycle();
    cycle(1'b1, 1'b1, 4'hF, MB, 32'h5A, 1'b0);
    apply(1'b0, 1'b0, 4'h0, MB, 32'h0, 1'b0);
    chk("rst_gpio_discard", 32'(gpio_out), 32'h0);
    finish_cycle();
    apply(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    chk("ram_retained", rd, 32'hAABB_11DD);
    finish_cycle();
    apply(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    chk("ram_wr_in_reset", rd, 32'hDEAD_BEEF);
    finish_cycle();

    // Random traffic; tx_ready held low in alternate 100-cycle phases to fill the FIFO
    for (int n = 0; n < 2000; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 4) begin
        ad_r = 32'($urandom_range(0, DW * 4 - 1));
      end else if (k < 8) begin
        ad_r = MB + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) ad_r = ad_r + 32'h8;
        else ad_r = ad_r + 32'($urandom_range(0, 5) * 4);
      end else if (k == 8) begin
        ad_r = MB + 32'h20 + 32'($urandom_range(0, 1000) * 4);
      end else begin
        ad_r = $urandom;
        if (is_ram(ad_r) || ad_r[31:12] == MB[31:12]) ad_r = 32'h0000_2000;
      end
      be_r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      cycle(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), be_r, ad_r, $urandom,
            ((n / 100) % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
